// File: rtl/led_cmd_pkg.sv
// Shared constants and types for the LED command scheduler: legal command
// bytes, FSM state encoding and arbitration source encoding.
package led_cmd_pkg;

  localparam logic [7:0] CMD_RED_ON    = 8'h52;  // 'R'
  localparam logic [7:0] CMD_RED_OFF   = 8'h72;  // 'r'
  localparam logic [7:0] CMD_GREEN_ON  = 8'h47;  // 'G'
  localparam logic [7:0] CMD_GREEN_OFF = 8'h67;  // 'g'
  localparam logic [7:0] CMD_BLUE_ON   = 8'h42;  // 'B'
  localparam logic [7:0] CMD_BLUE_OFF  = 8'h62;  // 'b'

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  typedef enum logic {
    SRC_FIFO  = 1'b0,
    SRC_LOCAL = 1'b1
  } src_t;

  function automatic logic is_legal_cmd(input logic [7:0] b);
    return (b == CMD_RED_ON)   || (b == CMD_RED_OFF)   ||
           (b == CMD_GREEN_ON) || (b == CMD_GREEN_OFF) ||
           (b == CMD_BLUE_ON)  || (b == CMD_BLUE_OFF);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small first-word-fall-through byte FIFO for buffering UART commands.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // Full-with-pop is safe: the head is read combinationally before the write lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/led_cmd_scheduler.sv
// Shares the LED controller's command input between buffered UART bytes and a
// local valid/ready source, with round-robin arbitration and an enforced gap.
module led_cmd_scheduler
  import led_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_done,
  input  logic [7:0]                  loc_byte,
  input  logic                        loc_valid,
  output logic                        loc_ready,
  output logic [7:0]                  cmd_byte,
  output logic                        cmd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt,
  output logic                        busy,
  input  logic                        clr_status
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        state_reg;
  src_t          last_grant_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [7:0]    cmd_byte_reg;
  logic          cmd_valid_reg;
  logic          overflow_reg;
  logic [7:0]    drop_cnt_reg;

  logic       rx_legal;
  logic       loc_legal;
  logic       fifo_req;
  logic       loc_req;
  logic       grant_fifo;
  logic       grant_loc;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       ovf_event;
  logic       rx_drop;
  logic       loc_drop;
  logic [8:0] drop_sum;
  logic [7:0] drop_cnt_next;
  logic       overflow_next;

  assign rx_legal  = is_legal_cmd(rx_byte);
  assign loc_legal = is_legal_cmd(loc_byte);
  assign fifo_req  = !fifo_empty;
  assign loc_req   = loc_valid && loc_legal;

  cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_done && rx_legal),
    .pop   (grant_fifo),
    .din   (rx_byte),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Round-robin: on a tie the source that did not win last time is granted.
  always_comb begin
    grant_fifo = 1'b0;
    grant_loc  = 1'b0;
    if (state_reg == ST_IDLE) begin
      if (fifo_req && loc_req) begin
        if (last_grant_reg == SRC_FIFO) grant_loc  = 1'b1;
        else                            grant_fifo = 1'b1;
      end else if (fifo_req) begin
        grant_fifo = 1'b1;
      end else if (loc_req) begin
        grant_loc = 1'b1;
      end
    end
  end

  // Illegal local bytes are acknowledged at once so the source never stalls on them.
  assign loc_ready = !rst && loc_valid && (!loc_legal || grant_loc);

  assign ovf_event = rx_done && rx_legal && fifo_full && !grant_fifo;
  assign rx_drop   = rx_done && !rx_legal;
  assign loc_drop  = loc_valid && !loc_legal;

  // Clear applies first, so events in the clearing cycle still register.
  always_comb begin
    drop_sum      = {1'b0, (clr_status ? 8'd0 : drop_cnt_reg)} + 9'(rx_drop) + 9'(loc_drop);
    drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    overflow_next = (overflow_reg && !clr_status) || ovf_event;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= SRC_LOCAL;
      gap_cnt_reg    <= '0;
      cmd_byte_reg   <= 8'h00;
      cmd_valid_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_cnt_reg   <= 8'h00;
    end else begin
      overflow_reg  <= overflow_next;
      drop_cnt_reg  <= drop_cnt_next;
      cmd_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_fifo || grant_loc) begin
            cmd_byte_reg   <= grant_fifo ? fifo_dout : loc_byte;
            cmd_valid_reg  <= 1'b1;
            last_grant_reg <= grant_fifo ? SRC_FIFO : SRC_LOCAL;
            gap_cnt_reg    <= GW'(GAP_CYCLES - 1);
            state_reg      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == '0) state_reg   <= ST_IDLE;
          else                   gap_cnt_reg <= gap_cnt_reg - 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_byte  = cmd_byte_reg;
  assign cmd_valid = cmd_valid_reg;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign busy      = (state_reg == ST_GAP) || !fifo_empty;

endmodule

// File: tb/tb_led_cmd_scheduler.sv
// Scoreboard bench for led_cmd_scheduler: expected command bytes are queued as
// stimulus is driven and checked in order whenever cmd_valid pulses.
module tb_led_cmd_scheduler;

  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_done = 1'b0;
  logic [7:0]    loc_byte = 8'h00;
  logic          loc_valid = 1'b0;
  logic          loc_ready;
  logic [7:0]    cmd_byte;
  logic          cmd_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          busy;
  logic          clr_status = 1'b0;

  led_cmd_scheduler #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_done    (rx_done),
    .loc_byte   (loc_byte),
    .loc_valid  (loc_valid),
    .loc_ready  (loc_ready),
    .cmd_byte   (cmd_byte),
    .cmd_valid  (cmd_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .busy       (busy),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         issue_q[$];

  function automatic bit tb_legal(input logic [7:0] b);
    case (b)
      8'h52, 8'h72, 8'h47, 8'h67, 8'h42, 8'h62: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard: every issued command must match the oldest expected byte.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      logic [7:0] e;
      n_cmp++;
      issue_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_unexpected: got cmd_byte=%h at cycle %0d, required no issue", cmd_byte, cyc);
      end else begin
        e = exp_q.pop_front();
        if (cmd_byte !== e) begin
          n_bad++;
          $display("FAIL scoreboard_byte: got %h, required %h (cycle %0d)", cmd_byte, e, cyc);
        end else begin
          $display("issue cmd_byte=%h cycle=%0d", cmd_byte, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_issue(input int want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (issue_q.size() >= want) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    loc_byte  = 8'h30;
    loc_valid = 1'b1;
    rx_byte   = 8'h41;
    rx_done   = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp += 7;
    if (loc_ready !== 1'b0) begin n_bad++; $display("FAIL reset_loc_ready_illegal: got %b, required 0", loc_ready); end
    if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_valid: got %b, required 0", cmd_valid); end
    if (cmd_byte !== 8'h00) begin n_bad++; $display("FAIL reset_cmd_byte: got %h, required 00", cmd_byte); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL reset_fifo_count: got %0d, required 0", fifo_count); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    if (drop_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    loc_byte = 8'h52;
    #1;
    n_cmp++;
    if (loc_ready !== 1'b0) begin n_bad++; $display("FAIL reset_loc_ready_legal: got %b, required 0", loc_ready); end
    tick();
    loc_valid = 1'b0;
    rx_done   = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    int c0;
    bit ok;
    issue_q.delete();
    exp_q.push_back(8'h52);
    c0 = cyc;
    send_rx(8'h52);
    @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_after_push: got %b, required 1", busy); end
    if (fifo_count !== CW'(1)) begin n_bad++; $display("FAIL single_fifo_count: got %0d, required 1", fifo_count); end
    wait_drain(100, ok);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL single_drain_timeout: got pending=%0d, required 0", exp_q.size()); end
    if (issue_q.size() != 1) begin
      n_bad++; $display("FAIL single_issue_count: got %0d, required 1", issue_q.size());
    end else if (issue_q[0] != c0 + 2) begin
      n_bad++; $display("FAIL single_latency: got cycle %0d, required %0d", issue_q[0], c0 + 2);
    end
    $display("test_single done");
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5] = '{8'h52, 8'h47, 8'h42, 8'h72, 8'h67};
    bit ok;
    issue_q.delete();
    exp_q.push_back(8'h62);
    send_rx(8'h62);
    wait_issue(1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL overflow_first_issue_timeout: got 0 issues, required 1"); end
    for (int i = 0; i < 5; i++) begin
      if (i < FIFO_DEPTH) exp_q.push_back(bytes[i]);
      send_rx(bytes[i]);
    end
    @(negedge clk);
    n_cmp += 2;
    if (fifo_count !== CW'(FIFO_DEPTH)) begin n_bad++; $display("FAIL overflow_fifo_peak: got %0d, required %0d", fifo_count, FIFO_DEPTH); end
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_flag: got %b, required 1", overflow); end
    wait_drain(300, ok);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL overflow_drain_timeout: got pending=%0d, required 0", exp_q.size()); end
    if (issue_q.size() != 5) begin
      n_bad++; $display("FAIL overflow_issue_count: got %0d, required 5", issue_q.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        n_cmp++;
        if (issue_q[i] - issue_q[i-1] != GAP_CYCLES + 1) begin
          n_bad++; $display("FAIL overflow_spacing_%0d: got %0d, required %0d", i, issue_q[i] - issue_q[i-1], GAP_CYCLES + 1);
        end
      end
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL overflow_clear: got %b, required 0", overflow); end
    tick();
    $display("test_overflow done");
  endtask

  task automatic test_illegal();
    logic [7:0] b;
    issue_q.delete();
    rx_byte   = 8'h41;
    rx_done   = 1'b1;
    loc_byte  = 8'h00;
    loc_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (loc_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_loc_ready: got %b, required 1", loc_ready); end
    tick();
    rx_done   = 1'b0;
    loc_valid = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL illegal_pair_drop_cnt: got %0d, required 2", drop_cnt); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL illegal_busy: got %b, required 0", busy); end
    tick();
    rx_done = 1'b1;
    for (int i = 0; i < 300; i++) begin
      do b = 8'($urandom); while (tb_legal(b));
      rx_byte = b;
      tick();
    end
    rx_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL illegal_saturate: got %0d, required 255", drop_cnt); end
    tick();
    clr_status = 1'b1;
    rx_byte    = 8'hFF;
    rx_done    = 1'b1;
    tick();
    clr_status = 1'b0;
    rx_done    = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL illegal_clear_plus_drop: got %0d, required 1", drop_cnt); end
    if (issue_q.size() != 0) begin n_bad++; $display("FAIL illegal_no_issue: got %0d issues, required 0", issue_q.size()); end
    tick();
    $display("test_illegal done");
  endtask

  task automatic test_tie();
    int pulses = 0;
    int rdy_cyc = 0;
    bit first_ready;
    bit seen;
    bit ok;
    do_reset();
    issue_q.delete();
    exp_q.push_back(8'h47);
    exp_q.push_back(8'h62);
    send_rx(8'h47);
    loc_byte  = 8'h62;
    loc_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = (loc_ready === 1'b1);
      if (i == 0) first_ready = seen;
      if (seen) begin
        pulses++;
        rdy_cyc = cyc;
      end
      tick();
      if (seen) loc_valid = 1'b0;
    end
    loc_valid = 1'b0;
    wait_drain(100, ok);
    n_cmp += 4;
    if (!ok) begin n_bad++; $display("FAIL tie_drain_timeout: got pending=%0d, required 0", exp_q.size()); end
    if (first_ready !== 1'b0) begin n_bad++; $display("FAIL tie_fifo_wins_first: got loc_ready=%b, required 0", first_ready); end
    if (pulses != 1) begin n_bad++; $display("FAIL tie_ready_pulses: got %0d, required 1", pulses); end
    if (issue_q.size() != 2) begin
      n_bad++; $display("FAIL tie_issue_count: got %0d, required 2", issue_q.size());
    end else begin
      n_cmp += 2;
      if (issue_q[1] - issue_q[0] != GAP_CYCLES + 1) begin
        n_bad++; $display("FAIL tie_spacing: got %0d, required %0d", issue_q[1] - issue_q[0], GAP_CYCLES + 1);
      end
      if (issue_q[1] != rdy_cyc + 1) begin
        n_bad++; $display("FAIL tie_ready_to_issue: got issue %0d, required %0d", issue_q[1], rdy_cyc + 1);
      end
    end
    $display("test_tie done");
  endtask

  task automatic test_local_gap();
    int pulses = 0;
    int early = 0;
    int rdy_cyc = 0;
    int r_cyc;
    bit seen;
    bit ok;
    issue_q.delete();
    exp_q.push_back(8'h52);
    send_rx(8'h52);
    wait_issue(1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL local_gap_first_issue_timeout: got 0 issues, required 1"); end
    r_cyc = (issue_q.size() > 0) ? issue_q[0] : 0;
    exp_q.push_back(8'h42);
    loc_byte  = 8'h42;
    loc_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen = (loc_ready === 1'b1);
      if (seen) begin
        pulses++;
        rdy_cyc = cyc;
        if (busy === 1'b1) early++;
      end
      tick();
      if (seen) loc_valid = 1'b0;
    end
    loc_valid = 1'b0;
    wait_drain(100, ok);
    n_cmp += 5;
    if (!ok) begin n_bad++; $display("FAIL local_gap_drain_timeout: got pending=%0d, required 0", exp_q.size()); end
    if (early != 0) begin n_bad++; $display("FAIL local_gap_ready_in_gap: got %0d, required 0", early); end
    if (pulses != 1) begin n_bad++; $display("FAIL local_gap_ready_pulses: got %0d, required 1", pulses); end
    if (rdy_cyc - r_cyc != GAP_CYCLES) begin
      n_bad++; $display("FAIL local_gap_ready_time: got %0d, required %0d", rdy_cyc - r_cyc, GAP_CYCLES);
    end
    if (issue_q.size() != 2) begin
      n_bad++; $display("FAIL local_gap_issue_count: got %0d, required 2", issue_q.size());
    end else begin
      n_cmp++;
      if (issue_q[1] != rdy_cyc + 1) begin
        n_bad++; $display("FAIL local_gap_issue_time: got %0d, required %0d", issue_q[1], rdy_cyc + 1);
      end
    end
    $display("test_local_gap done");
  endtask

  task automatic test_reset_mid_gap();
    bit ok;
    issue_q.delete();
    exp_q.push_back(8'h47);
    send_rx(8'h47);
    wait_issue(1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midgap_first_issue_timeout: got 0 issues, required 1"); end
    send_rx(8'h52);
    send_rx(8'h67);
    send_rx(8'h62);
    @(negedge clk);
    n_cmp++;
    if (fifo_count !== CW'(3)) begin n_bad++; $display("FAIL midgap_queued: got %0d, required 3", fifo_count); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    n_cmp += 5;
    if (cmd_byte !== 8'h00) begin n_bad++; $display("FAIL midgap_cmd_byte: got %h, required 00", cmd_byte); end
    if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL midgap_cmd_valid: got %b, required 0", cmd_valid); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL midgap_fifo_count: got %0d, required 0", fifo_count); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midgap_busy: got %b, required 0", busy); end
    if (drop_cnt !== 8'h00) begin n_bad++; $display("FAIL midgap_drop_cnt: got %0d, required 0", drop_cnt); end
    tick();
    tick();
    rst = 1'b0;
    issue_q.delete();
    repeat (40) tick();
    @(negedge clk);
    n_cmp += 3;
    if (issue_q.size() != 0) begin n_bad++; $display("FAIL midgap_stale_issue: got %0d, required 0", issue_q.size()); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL midgap_fifo_after: got %0d, required 0", fifo_count); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midgap_busy_after: got %b, required 0", busy); end
    tick();
    $display("test_reset_mid_gap done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_illegal();
    test_tie();
    test_local_gap();
    test_reset_mid_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
